tri_fetcher: RTL
================

TRI_FETCHER -- requirements
Module: tri_fetcher

Interface
REQ-001 Parameter NDWORDS, default 9: 32-bit words per element.
REQ-002 Parameter ELEMSZ, default 32*NDWORDS: element width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, >=2): output buffer entries.
REQ-004 Parameter TIMEOUT, default 4096: maximum cycles spent waiting for one element.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse that begins a fetch pass; ignored while busy.
REQ-008 nelems  in  32  element count, sampled on accepted start.
REQ-009 busy  out  1  high from accepted start until done.
REQ-010 done  out  1  single-cycle pulse at pass end.
REQ-011 err  out  1  sticky timeout flag; cleared by the next accepted start.
REQ-012 rd_read  out  1  element request strobe to the cached element reader.
REQ-013 rd_index  out  32  element index to the reader.
REQ-014 rd_iready  in  1  reader ready to accept a request.
REQ-015 rd_data  in  ELEMSZ  element data from the reader.
REQ-016 rd_ovalid  in  1  reader data valid.
REQ-017 o_elem  out  ELEMSZ  buffered element to the consumer.
REQ-018 o_index  out  32  index of o_elem.
REQ-019 o_last  out  1  o_elem is element nelems-1.
REQ-020 o_valid  out  1  output entry available.
REQ-021 o_ready  in  1  consumer accepts; transfer when o_valid && o_ready.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, DRAIN.
REQ-023 IDLE: start with nelems!=0 -> latch nelems, clear index counter and err, busy=1, go to ISSUE.
REQ-024 IDLE: start with nelems==0 -> done pulses next cycle, busy stays 0, err cleared, state stays IDLE.
REQ-025 ISSUE: rd_read=1 and rd_index=counter only when rd_iready=1 and FIFO count<FIFO_DEPTH; then go to WAIT the next cycle.
REQ-026 rd_read SHALL be high for exactly one cycle per element; only one request is outstanding at any time.
REQ-027 rd_index SHALL hold the counter value from issue until rd_ovalid is accepted.
REQ-028 WAIT: rd_ovalid is sampled only from the first cycle after the rd_read cycle; rd_ovalid in IDLE, ISSUE or DRAIN is ignored.
REQ-029 WAIT with rd_ovalid=1: push {rd_data, counter, counter==nelems-1} to the FIFO and increment the counter. Then go to DRAIN if it was the last element, else to ISSUE.
REQ-030 Counter arithmetic is 32-bit unsigned; the last-element compare is against latched nelems-1.
REQ-031 The wait counter clears on entering WAIT and increments each WAIT cycle without rd_ovalid.
REQ-032 If the wait counter reaches TIMEOUT-1 without rd_ovalid: set err=1, flush the FIFO, then on the next cycle pulse done, drop busy and go to IDLE. Any later rd_ovalid is ignored.
REQ-033 DRAIN: when the FIFO is empty, pulse done, drop busy and go to IDLE. done is coincident with busy falling.
REQ-034 FIFO: first-word fall-through; o_valid=!empty; o_elem, o_index and o_last come from the head entry.
REQ-035 Simultaneous push and pop on a full FIFO is disallowed by REQ-025. Simultaneous push and pop otherwise leaves the count unchanged.
REQ-036 Pop on empty and push on full SHALL never occur; output order equals index order 0..nelems-1.
REQ-037 A start during busy SHALL have no effect.

Reset
REQ-038 On reset assertion, immediately and asynchronously: state=IDLE; counter, wait counter and FIFO pointers/count = 0.
REQ-039 On reset assertion, all outputs go low: busy, done, err, rd_read, o_valid and o_last = 0; rd_index, o_index and o_elem = 0.
REQ-040 Reset mid-pass abandons any outstanding reader request; post-reset rd_ovalid is ignored until a new request is issued.

Verification
REQ-041 nelems=3, reader responds 1 cycle after each rd_read, o_ready=1 -> rd_index 0,1,2; outputs index 0,1,2; o_last only on index 2; one done pulse; err=0.
REQ-042 nelems=8, FIFO_DEPTH=4, o_ready=0 -> exactly 4 rd_read pulses, o_valid=1. Then o_ready=1 -> remaining 4 are fetched, all 8 delivered in order, done after last pop.
REQ-043 rd_ovalid held high in IDLE and on the rd_read cycle, with the real response 5 cycles later -> only the WAIT-phase sample is captured; each element is pushed once.
REQ-044 TIMEOUT=16, rd_ovalid never asserted -> err=1, done pulse 17 cycles after rd_read, FIFO empty, busy=0. The next start clears err.
REQ-045 start with nelems=0 -> done pulse, no rd_read. A start during a busy pass is ignored.
REQ-046 reset asserted mid-WAIT with 2 FIFO entries -> all outputs 0 in the same cycle; a fresh start with nelems=1 completes normally.

Source files
------------

// File: rtl/tri_fetcher_if.sv
// Signal bundle shared by tri_fetcher, the pass controller, the cached element
// reader and the downstream consumer.
interface tri_fetcher_if #(
    parameter int ELEMSZ = 288
);
    logic              start;
    logic [31:0]       nelems;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_read;
    logic [31:0]       rd_index;
    logic              rd_iready;
    logic [ELEMSZ-1:0] rd_data;
    logic              rd_ovalid;
    logic [ELEMSZ-1:0] o_elem;
    logic [31:0]       o_index;
    logic              o_last;
    logic              o_valid;
    logic              o_ready;

    modport master (
        output start, nelems, rd_iready, rd_data, rd_ovalid, o_ready,
        input  busy, done, err, rd_read, rd_index, o_elem, o_index, o_last, o_valid
    );

    modport slave (
        input  start, nelems, rd_iready, rd_data, rd_ovalid, o_ready,
        output busy, done, err, rd_read, rd_index, o_elem, o_index, o_last, o_valid
    );
endinterface

// File: rtl/tri_fetcher.sv
// Fetches elements 0..nelems-1 from a cached reader, one request in flight at a time,
// and hands them to a consumer through a small first-word fall-through buffer.
module tri_fetcher #(
    parameter int NDWORDS    = 9,
    parameter int ELEMSZ     = 32 * NDWORDS,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic         clk,
    input  logic         reset,
    tri_fetcher_if.slave bus
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
    state_t state_q, state_d;

    logic              busy_q, done_q, err_q;
    logic [31:0]       nelems_q, cnt_q, wcnt_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic [ELEMSZ-1:0] mem_elem  [FIFO_DEPTH];
    logic [31:0]       mem_index [FIFO_DEPTH];
    logic              mem_last  [FIFO_DEPTH];

    logic launch, zero_start, issue, accept, timeout_hit, finish;
    logic is_last, fifo_empty, fifo_pop;

    assign is_last    = (cnt_q == nelems_q - 32'd1);
    assign fifo_empty = (count_q == '0);
    assign fifo_pop   = !fifo_empty && bus.o_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A request is only issued when the buffer has room, so a push never meets a full FIFO.
    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        zero_start  = 1'b0;
        issue       = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        finish      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.nelems != 32'd0) begin
                        launch  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.rd_iready && (count_q < DEPTH_C)) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.rd_ovalid) begin
                    accept  = 1'b1;
                    state_d = is_last ? DRAIN : ISSUE;
                end else if (wcnt_q == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            nelems_q <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            done_q <= zero_start | finish | timeout_hit;
            if (launch) begin
                busy_q   <= 1'b1;
                err_q    <= 1'b0;
                nelems_q <= bus.nelems;
                cnt_q    <= '0;
            end
            if (zero_start) err_q <= 1'b0;
            if (finish || timeout_hit) busy_q <= 1'b0;
            if (accept) cnt_q <= cnt_q + 32'd1;

            if (issue)                                wcnt_q <= '0;
            else if (state_q == WAIT && !bus.rd_ovalid) wcnt_q <= wcnt_q + 32'd1;

            // A timeout discards whatever was buffered for the abandoned pass.
            if (timeout_hit) begin
                err_q    <= 1'b1;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (accept)   wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({accept, fifo_pop})
                    2'b10:   count_q <= count_q + (AW + 1)'(1);
                    2'b01:   count_q <= count_q - (AW + 1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_elem[wr_ptr_q]  <= bus.rd_data;
            mem_index[wr_ptr_q] <= cnt_q;
            mem_last[wr_ptr_q]  <= is_last;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rd_read  = issue;
    assign bus.rd_index = (issue || state_q == WAIT) ? cnt_q : 32'd0;
    assign bus.o_valid  = !fifo_empty;
    assign bus.o_elem   = fifo_empty ? '0    : mem_elem[rd_ptr_q];
    assign bus.o_index  = fifo_empty ? 32'd0 : mem_index[rd_ptr_q];
    assign bus.o_last   = fifo_empty ? 1'b0  : mem_last[rd_ptr_q];
endmodule
